// File: rtl/tmem_pkg.sv
// Shared types and constants for the tmem_bist test memory and its March C- engine.
package tmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_M4   = 3'd5,
        ST_M5   = 3'd6,
        ST_DONE = 3'd7
    } march_state_e;

    typedef enum logic [1:0] {
        PH_RD  = 2'd0,
        PH_WR  = 2'd1,
        PH_CMP = 2'd2
    } march_phase_e;

    // Background bit values; replicated across the word width by the engine.
    localparam logic BG_ZERO = 1'b0;
    localparam logic BG_ONE  = 1'b1;

    // Busy cycles of a fault-free march: M0 one cycle per word, M1..M5 two each.
    function automatic int march_len(input int addr_w);
        return 11 * (1 << addr_w);
    endfunction

endpackage

// File: rtl/tmem_array.sv
// Single-port storage with read-first registered read. The functional and BIST
// sides share the one port; each side has its own read register so BIST reads
// never disturb the functional read_data. Optional stuck-at overlay on reads
// (TMEM_FAULT_INJECT_EN).
module tmem_array
    import tmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bist_sel,
    input  logic                      f_we,
    input  logic                      f_re,
    input  logic [ADDR_W-1:0]         f_addr,
    input  logic [DATA_W-1:0]         f_wdata,
    input  logic                      b_we,
    input  logic                      b_re,
    input  logic [ADDR_W-1:0]         b_addr,
    input  logic [DATA_W-1:0]         b_wdata,
`ifdef TMEM_FAULT_INJECT_EN
    input  logic                      fi_en,
    input  logic [ADDR_W-1:0]         fi_addr,
    input  logic [$clog2(DATA_W)-1:0] fi_bit,
    input  logic                      fi_val,
`endif
    output logic [DATA_W-1:0]         f_rdata,
    output logic                      f_rvalid,
    output logic [DATA_W-1:0]         b_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] f_rdata_d, f_rdata_q;
    logic              f_rvalid_d, f_rvalid_q;
    logic [DATA_W-1:0] b_rdata_d, b_rdata_q;

    // Port mux and read word (with optional stuck-at overlay).
    always_comb begin
        we      = bist_sel ? b_we    : f_we;
        a       = bist_sel ? b_addr  : f_addr;
        wd      = bist_sel ? b_wdata : f_wdata;
        rd_word = mem_q[a];
`ifdef TMEM_FAULT_INJECT_EN
        if (fi_en && (a == fi_addr))
            rd_word[fi_bit] = fi_val;
`endif
    end

    // Storage write; the old word is sampled by the read registers on the same edge.
    always_ff @(posedge clk) begin
        if (we)
            mem_q[a] <= wd;
    end

    // Next values for the read registers.
    always_comb begin
        f_rdata_d  = (!bist_sel && f_re) ? rd_word : f_rdata_q;
        f_rvalid_d = !bist_sel && f_re;
        b_rdata_d  = (bist_sel && b_re) ? rd_word : b_rdata_q;
    end

    // Read registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_rdata_q  <= '0;
            f_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            f_rdata_q  <= f_rdata_d;
            f_rvalid_q <= f_rvalid_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign f_rdata  = f_rdata_q;
    assign f_rvalid = f_rvalid_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: rtl/tmem_bist.sv
// Test memory with integrated March C- self-test. Optional stuck-at fault
// injection ports are present when TMEM_FAULT_INJECT_EN is defined.
//
// state   | meaning
// IDLE    | no march since reset; functional port active
// M0      | up, write background 0 (1 cycle/word)
// M1      | up, read expect 0, write 1 (RD/WR)
// M2      | up, read expect 1, write 0 (RD/WR)
// M3      | down, read expect 0, write 1 (RD/WR)
// M4      | down, read expect 1, write 0 (RD/WR)
// M5      | up, read expect 0 (RD/CMP)
// DONE    | march finished; done/fail held until next start
module tmem_bist
    import tmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_en,
    input  logic                      read_en,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         write_data,
    output logic [DATA_W-1:0]         read_data,
    output logic                      read_valid,
    input  logic                      bist_start,
    output logic                      bist_busy,
    output logic                      bist_done,
    output logic                      bist_fail,
`ifdef TMEM_FAULT_INJECT_EN
    input  logic                      fi_en,
    input  logic [ADDR_W-1:0]         fi_addr,
    input  logic [$clog2(DATA_W)-1:0] fi_bit,
    input  logic                      fi_val,
`endif
    output logic [ADDR_W-1:0]         bist_fail_addr
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    march_state_e      state_d, state_q;
    march_phase_e      phase_d, phase_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              fail_d, fail_q;
    logic [ADDR_W-1:0] fail_addr_d, fail_addr_q;
    logic              done_d, done_q;

    logic              b_we, b_re;
    logic [DATA_W-1:0] b_wdata, b_rdata;

    logic              elem_up, exp_bit;
    march_state_e      next_elem;
    logic [ADDR_W-1:0] term_addr, next_start, addr_step;
    logic [DATA_W-1:0] exp_word;

    assign bist_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

    tmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk      (clk),
        .rst      (rst),
        .bist_sel (bist_busy),
        .f_we     (write_en),
        .f_re     (read_en),
        .f_addr   (addr),
        .f_wdata  (write_data),
        .b_we     (b_we),
        .b_re     (b_re),
        .b_addr   (addr_q),
        .b_wdata  (b_wdata),
`ifdef TMEM_FAULT_INJECT_EN
        .fi_en    (fi_en),
        .fi_addr  (fi_addr),
        .fi_bit   (fi_bit),
        .fi_val   (fi_val),
`endif
        .f_rdata  (read_data),
        .f_rvalid (read_valid),
        .b_rdata  (b_rdata)
    );

    // Per-element direction, expected background and successor element.
    always_comb begin
        elem_up   = 1'b1;
        exp_bit   = BG_ZERO;
        next_elem = ST_DONE;
        unique case (state_q)
            ST_M1:   begin elem_up = 1'b1; exp_bit = BG_ZERO; next_elem = ST_M2; end
            ST_M2:   begin elem_up = 1'b1; exp_bit = BG_ONE;  next_elem = ST_M3; end
            ST_M3:   begin elem_up = 1'b0; exp_bit = BG_ZERO; next_elem = ST_M4; end
            ST_M4:   begin elem_up = 1'b0; exp_bit = BG_ONE;  next_elem = ST_M5; end
            ST_M5:   begin elem_up = 1'b1; exp_bit = BG_ZERO; next_elem = ST_DONE; end
            default: begin elem_up = 1'b1; exp_bit = BG_ZERO; next_elem = ST_M1; end
        endcase
        exp_word   = {DATA_W{exp_bit}};
        term_addr  = elem_up ? ADDR_LAST : '0;
        addr_step  = elem_up ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
        next_start = ((next_elem == ST_M3) || (next_elem == ST_M4)) ? ADDR_LAST : '0;
    end

    // March sequencer: next state, address walk, flags and BIST array strobes.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        done_d      = done_q;
        b_we        = 1'b0;
        b_re        = 1'b0;
        b_wdata     = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    state_d     = ST_M0;
                    phase_d     = PH_RD;
                    addr_d      = '0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    done_d      = 1'b0;
                end
            end
            ST_M0: begin
                b_we    = 1'b1;
                b_wdata = {DATA_W{BG_ZERO}};
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_M1;
                    phase_d = PH_RD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
                if (phase_q == PH_RD) begin
                    b_re    = 1'b1;
                    phase_d = (state_q == ST_M5) ? PH_CMP : PH_WR;
                end else if (b_rdata != exp_word) begin
                    fail_d      = 1'b1;
                    fail_addr_d = addr_q;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    b_we    = (state_q != ST_M5);
                    b_wdata = ~exp_word;
                    phase_d = PH_RD;
                    if (addr_q == term_addr) begin
                        state_d = next_elem;
                        addr_d  = next_start;
                        done_d  = (next_elem == ST_DONE);
                    end else begin
                        addr_d = addr_step;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_RD;
            addr_q      <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            done_q      <= done_d;
        end
    end

    assign bist_done      = done_q;
    assign bist_fail      = fail_q;
    assign bist_fail_addr = fail_addr_q;

endmodule

// File: tb/tb_tmem_bist.sv
// Directed bench for tmem_bist: functional access, read-first, March C- pass,
// ignored restart, reset mid-march, and (optionally) stuck-at detection.
module tb_tmem_bist;

    logic       clk;
    logic       rst;
    logic       write_en;
    logic       read_en;
    logic [7:0] addr;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       read_valid;
    logic       bist_start;
    logic       bist_busy;
    logic       bist_done;
    logic       bist_fail;
    logic [7:0] bist_fail_addr;
`ifdef TMEM_FAULT_INJECT_EN
    logic       fi_en;
    logic [7:0] fi_addr;
    logic [2:0] fi_bit;
    logic       fi_val;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    tmem_bist #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .write_en       (write_en),
        .read_en        (read_en),
        .addr           (addr),
        .write_data     (write_data),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
`ifdef TMEM_FAULT_INJECT_EN
        .fi_en          (fi_en),
        .fi_addr        (fi_addr),
        .fi_bit         (fi_bit),
        .fi_val         (fi_val),
`endif
        .bist_fail_addr (bist_fail_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, bist_busy},  32'd0);
        chk({tag, "_done"},  {31'd0, bist_done},  32'd0);
        chk({tag, "_fail"},  {31'd0, bist_fail},  32'd0);
        chk({tag, "_faddr"}, {24'd0, bist_fail_addr}, 32'd0);
        chk({tag, "_rdata"}, {24'd0, read_data},  32'd0);
        chk({tag, "_rvalid"},{31'd0, read_valid}, 32'd0);
    endtask

    // Runs until bist_busy falls (bounded); optionally hammers the functional
    // port and re-pulses bist_start at busy cycle 100.
    task automatic run_march(input bit traffic, output int cycles, output bit rv_seen);
        cycles  = 0;
        rv_seen = 1'b0;
        while (bist_busy && cycles < 5000) begin
            cycles++;
            rv_seen    = rv_seen | read_valid;
            bist_start = traffic && (cycles == 100);
            write_en   = traffic;
            read_en    = traffic;
            addr       = 8'($urandom);
            write_data = 8'($urandom_range(1, 255));
            tick();
        end
        bist_start = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
    endtask

    int cyc;
    bit rvs;

    initial begin
        rst        = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        addr       = '0;
        write_data = '0;
        bist_start = 1'b0;
`ifdef TMEM_FAULT_INJECT_EN
        fi_en   = 1'b0;
        fi_addr = '0;
        fi_bit  = '0;
        fi_val  = 1'b0;
`endif
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // Fill addr i with i, then read back.
        for (int i = 0; i < 256; i++) begin
            write_en   = 1'b1;
            addr       = 8'(i);
            write_data = 8'(i);
            tick();
        end
        write_en = 1'b0;
        chk("wr_no_valid", {31'd0, read_valid}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            read_en = 1'b1;
            addr    = 8'(i);
            tick();
            chk("rd_data",  {24'd0, read_data},  32'(i));
            chk("rd_valid", {31'd0, read_valid}, 32'd1);
        end
        read_en = 1'b0;
        tick();
        chk("rd_valid_drop", {31'd0, read_valid}, 32'd0);
        chk("rd_hold",       {24'd0, read_data},  32'hFF);

        // Read-first collision at 0x10.
        write_en = 1'b1; addr = 8'h10; write_data = 8'h3C;
        tick();
        read_en = 1'b1; write_data = 8'hA5;
        tick();
        write_en = 1'b0;
        chk("rf_old",   {24'd0, read_data},  32'h3C);
        chk("rf_valid", {31'd0, read_valid}, 32'd1);
        tick();
        read_en = 1'b0;
        chk("rf_new", {24'd0, read_data}, 32'hA5);
        tick();
        chk("rf_hold",   {24'd0, read_data},  32'hA5);
        chk("rf_vdrop",  {31'd0, read_valid}, 32'd0);

        // Passing march with functional traffic and a mid-march restart pulse.
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        chk("start_busy", {31'd0, bist_busy}, 32'd1);
        chk("start_done", {31'd0, bist_done}, 32'd0);
        run_march(1'b1, cyc, rvs);
        chk("march_len",   32'(cyc), 32'd2816);
        chk("march_done",  {31'd0, bist_done}, 32'd1);
        chk("march_fail",  {31'd0, bist_fail}, 32'd0);
        chk("march_rv",    {31'd0, rvs}, 32'd0);
        chk("march_rhold", {24'd0, read_data}, 32'hA5);
        for (int i = 0; i < 256; i++) begin
            read_en = 1'b1;
            addr    = 8'(i);
            tick();
            chk("post_zero", {24'd0, read_data}, 32'd0);
        end
        read_en = 1'b0;
        tick();
        chk("done_held", {31'd0, bist_done}, 32'd1);

        // Reset mid-march, then a full march afterwards.
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        chk("restart_clr_done", {31'd0, bist_done}, 32'd0);
        repeat (500) tick();
        chk("mid_busy", {31'd0, bist_busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        #2;
        rst = 1'b1;
        tick();
        chk_all_zero("after_rst");
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        run_march(1'b0, cyc, rvs);
        chk("rerun_len",  32'(cyc), 32'd2816);
        chk("rerun_done", {31'd0, bist_done}, 32'd1);
        chk("rerun_fail", {31'd0, bist_fail}, 32'd0);

`ifdef TMEM_FAULT_INJECT_EN
        // Stuck-at-1 on bit 3 of 0x42: caught on the M1 read of 0x42.
        fi_en = 1'b1; fi_addr = 8'h42; fi_bit = 3'd3; fi_val = 1'b1;
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        run_march(1'b0, cyc, rvs);
        chk("fi_len",   32'(cyc), 32'd390);
        chk("fi_done",  {31'd0, bist_done}, 32'd1);
        chk("fi_fail",  {31'd0, bist_fail}, 32'd1);
        chk("fi_faddr", {24'd0, bist_fail_addr}, 32'h42);
        fi_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tmem_bist.md
# tmem_bist

Parametrised successor of the 8×8 test memory: a single-port synchronous RAM with configurable width and depth, registered read with a valid strobe, and an integrated March C- self-test engine. It is the memory-under-test for the JTAG BIST chain. The functional port is used for normal access. The BIST controller (driven from the TAP data registers) starts the march and reads back pass/fail and the first failing address.

## Interface
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- DATA_W, 8, word width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- write_en  in  1  functional write strobe
- read_en  in  1  functional read strobe
- addr  in  ADDR_W  functional address
- write_data  in  DATA_W  functional write data
- read_data  out  DATA_W  registered read data
- read_valid  out  1  high for the one cycle read_data is updated by a read
- bist_start  in  1  single-cycle start pulse
- bist_busy  out  1  march in progress
- bist_done  out  1  level; march finished, held until next accepted bist_start
- bist_fail  out  1  level; mismatch detected, valid when bist_done
- bist_fail_addr  out  ADDR_W  address of first mismatch

## Operation
- Reset: read_data=0, read_valid=0, bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0. BIST FSM goes to IDLE. Array contents are not reset.
- Functional access (bist_busy=0):
  - write_en writes write_data to addr.
  - read_en loads read_data from addr.
  - Both strobes at the same addr: read returns the old word (read-first), and the write also completes.
  - With read_en low, read_data holds its value.
- bist_start is accepted only in IDLE or DONE. A pulse while busy is ignored. Accepting it clears bist_done, bist_fail and bist_fail_addr, and sets bist_busy.
- While bist_busy=1:
  - write_en, read_en, addr and write_data are ignored.
  - read_valid=0.
  - read_data holds its value.
- March C- FSM states:
  - IDLE
  - M0 ⇑w0
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑r0
  - DONE
- Background data: 0 = all-zero word, 1 = all-ones word.
- Up elements walk 0..DEPTH-1; down elements walk DEPTH-1..0. The address counter is ADDR_W bits, and the element ends when the counter hits its terminal value (no extra wrap cycle).
- M0: one cycle per address.
- M1–M4: two cycles per address.
  - RD phase issues the read.
  - WR phase compares the returned word against the expected background and writes the inverse.
- M5: two cycles per address (RD, CMP).
- First mismatch: set bist_fail, capture bist_fail_addr, abort straight to DONE. No further writes occur.
- DONE: bist_busy=0, bist_done=1.
- Reset during the march: FSM returns to IDLE, all flags clear, array contents are undefined.

## Timing
- Read latency 1: read_en sampled at edge n → read_data and read_valid=1 after edge n; read_valid drops after edge n+1 unless read_en is re-asserted.
- Write takes effect at the sampling edge; a read at edge n+1 sees it.
- bist_start sampled at edge n → bist_busy=1 after edge n, first M0 write at edge n+1.
- Passing march length: DEPTH + 8·DEPTH + 2·DEPTH = 11·DEPTH busy cycles (2816 for DEPTH=256). The bist_done rise coincides with the bist_busy fall.
- After a passing march, every word reads 0.

## Configuration
- TMEM_FAULT_INJECT_EN defined:
  - Adds inputs fi_en (1), fi_addr (ADDR_W), fi_bit ($clog2(DATA_W)), fi_val (1).
  - When fi_en=1, bit fi_bit of any read from fi_addr (functional or BIST) returns fi_val: a stuck-at fault.
  - Writes are unaffected.
- TMEM_FAULT_INJECT_EN undefined: the ports and the logic do not exist, and reads are always true array contents.

## Structure
- tmem_pkg:
  - march state enum (IDLE, M0..M5, DONE)
  - phase enum (RD, WR, CMP)
  - background constants
  - march length function of ADDR_W
- Sub-module tmem_array: the storage plus the read-first registered read port, muxed between the functional and BIST address/data. The fault-inject overlay sits on its read output.

## Test plan
- Reset, then write i to addr i for all 256 words, then read all → read_data=i one cycle after each read_en, with read_valid=1 only in those cycles.
- Write 0xA5 and read addr 0x10 in the same cycle, with 0x3C stored → read_data=0x3C; next read of 0x10 returns 0xA5.
- Pulse bist_start, fault-free → bist_busy for exactly 2816 cycles, then bist_done=1 and bist_fail=0; all words then read 0x00.
- TMEM_FAULT_INJECT_EN with fi_addr=0x42, fi_bit=3, fi_val=1 → bist_fail=1, bist_fail_addr=0x42, detected in M1.
- Pulse bist_start again mid-march → ignored, march length unchanged. Assert rst mid-march → all outputs 0, next bist_start runs a full march.
- Drive functional write_en/read_en throughout the march → no functional effect, read_valid stays 0, and the march passes.
